// File: rtl/bp_be_scoreboard_if.sv
// Issue/writeback bundle between the dispatch stage and the scoreboard.
// master: the issue stage. It drives the ISD candidate, the record qualifiers,
//         the long-op writebacks and flush, and it samples dispatch_v_o and
//         credits_o.
// slave : the scoreboard. It samples everything the master drives and
//         returns the hazard decision and the outstanding long-op count.
interface bp_be_scoreboard_if;
  logic       isd_v_i;
  logic       poison_i;
  logic       isd_irs1_v_i;
  logic       isd_irs2_v_i;
  logic       isd_frs1_v_i;
  logic       isd_frs2_v_i;
  logic       isd_frs3_v_i;
  logic [4:0] isd_rs1_addr_i;
  logic [4:0] isd_rs2_addr_i;
  logic [4:0] isd_rs3_addr_i;
  logic       isd_ird_w_v_i;
  logic       isd_frd_w_v_i;
  logic [4:0] isd_rd_addr_i;
  logic       isd_long_v_i;
  logic       isd_mem_v_i;
  logic       isd_fence_v_i;
  logic       iwb_v_i;
  logic [4:0] iwb_addr_i;
  logic       fwb_v_i;
  logic [4:0] fwb_addr_i;
  logic       flush_i;
  logic       dispatch_v_o;
  logic [3:0] credits_o;

  modport master (
    output isd_v_i, poison_i, isd_irs1_v_i, isd_irs2_v_i, isd_frs1_v_i,
           isd_frs2_v_i, isd_frs3_v_i, isd_rs1_addr_i, isd_rs2_addr_i,
           isd_rs3_addr_i, isd_ird_w_v_i, isd_frd_w_v_i, isd_rd_addr_i,
           isd_long_v_i, isd_mem_v_i, isd_fence_v_i, iwb_v_i, iwb_addr_i,
           fwb_v_i, fwb_addr_i, flush_i,
    input  dispatch_v_o, credits_o
  );

  modport slave (
    input  isd_v_i, poison_i, isd_irs1_v_i, isd_irs2_v_i, isd_frs1_v_i,
           isd_frs2_v_i, isd_frs3_v_i, isd_rs1_addr_i, isd_rs2_addr_i,
           isd_rs3_addr_i, isd_ird_w_v_i, isd_frd_w_v_i, isd_rd_addr_i,
           isd_long_v_i, isd_mem_v_i, isd_fence_v_i, iwb_v_i, iwb_addr_i,
           fwb_v_i, fwb_addr_i, flush_i,
    output dispatch_v_o, credits_o
  );
endinterface

// File: rtl/bp_be_scoreboard.sv
// Back-end issue scoreboard. It tracks busy int/FP destinations of
// long-latency ops, a credit count of outstanding long ops, and a short pipe
// of in-flight load destinations. From these it decides whether the ISD
// candidate may dispatch.
// Ports: clk_i, reset_i (synchronous, active high);
//        sb_if (slave) carries the ISD candidate, the writebacks, flush_i,
//        dispatch_v_o (combinational) and credits_o (registered).

// Credit counter sanity checks. Any saturation means that issue or
// writeback bookkeeping upstream is broken.
module bp_be_scoreboard_chk (
  input logic clk_i,
  input logic reset_i,
  input logic underflow_i,
  input logic overflow_i
);
  // Flag credit underflow/overflow outside reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!underflow_i) else $error("credit counter underflow");
      assert (!overflow_i)  else $error("credit counter overflow");
    end
  end
endmodule

module bp_be_scoreboard #(
  parameter int long_credits_p = 4,
  parameter int mem_latency_p  = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  bp_be_scoreboard_if.slave sb_if
);
  localparam logic        [3:0] max_credits_lp   = 4'(long_credits_p);
  localparam logic signed [5:0] max_credits_s_lp = 6'(long_credits_p);

  logic [31:0] ibusy_q, ibusy_d, fbusy_q, fbusy_d;
  logic [3:0]  credits_q, credits_d;
  logic [mem_latency_p-1:0]      pipe_v_q, pipe_v_d, pipe_fp_q, pipe_fp_d;
  logic [mem_latency_p-1:0][4:0] pipe_addr_q, pipe_addr_d;

  logic rec_s, long_rec_s, mem_rec_s;
  logic signed [5:0] cred_sum_s;
  logic underflow_s, overflow_s;
  logic [mem_latency_p:0]      ext_v_s, ext_fp_s;
  logic [mem_latency_p:0][4:0] ext_addr_s;
  logic [31:0] iacc_s [mem_latency_p+1];
  logic [31:0] facc_s [mem_latency_p+1];
  logic [31:0] ihaz_s, fhaz_s;
  logic src_haz_s, struct_haz_s, fence_haz_s;

  assign rec_s      = sb_if.isd_v_i & ~sb_if.poison_i;
  assign long_rec_s = rec_s & sb_if.isd_long_v_i;
  assign mem_rec_s  = rec_s & sb_if.isd_mem_v_i & (sb_if.isd_ird_w_v_i | sb_if.isd_frd_w_v_i);

  // Credit update: net -2..+1 per cycle, saturated at both ends.
  always_comb begin
    cred_sum_s = $signed({2'b00, credits_q})
               + $signed({5'b00000, long_rec_s})
               - $signed({5'b00000, sb_if.iwb_v_i})
               - $signed({5'b00000, sb_if.fwb_v_i});
    underflow_s = (cred_sum_s < 6'sd0);
    overflow_s  = (cred_sum_s > max_credits_s_lp);
    if (underflow_s) begin
      credits_d = 4'd0;
    end else if (overflow_s) begin
      credits_d = max_credits_lp;
    end else begin
      credits_d = cred_sum_s[3:0];
    end
  end

  // Busy vectors: clear on writeback first, then set on long record so that
  // a same-cycle set of the same register wins.
  always_comb begin
    ibusy_d = ibusy_q;
    fbusy_d = fbusy_q;
    ibusy_d[sb_if.iwb_addr_i] = ibusy_q[sb_if.iwb_addr_i] & ~sb_if.iwb_v_i;
    fbusy_d[sb_if.fwb_addr_i] = fbusy_q[sb_if.fwb_addr_i] & ~sb_if.fwb_v_i;
    ibusy_d[sb_if.isd_rd_addr_i] = ibusy_d[sb_if.isd_rd_addr_i] | (long_rec_s & sb_if.isd_ird_w_v_i);
    fbusy_d[sb_if.isd_rd_addr_i] = fbusy_d[sb_if.isd_rd_addr_i] | (long_rec_s & sb_if.isd_frd_w_v_i);
    ibusy_d[0] = 1'b0;
  end

  // Load pipe: the new entry goes in at the bottom, the top stage falls off.
  // Flush kills every stage, the incoming entry included.
  always_comb begin
    ext_v_s     = {pipe_v_q, mem_rec_s};
    ext_fp_s    = {pipe_fp_q, sb_if.isd_frd_w_v_i};
    ext_addr_s  = {pipe_addr_q, sb_if.isd_rd_addr_i};
    pipe_v_d    = sb_if.flush_i ? {mem_latency_p{1'b0}} : ext_v_s[mem_latency_p-1:0];
    pipe_fp_d   = ext_fp_s[mem_latency_p-1:0];
    pipe_addr_d = ext_addr_s[mem_latency_p-1:0];
  end

  // Per-stage decode of the load destinations, OR-accumulated into register masks.
  assign iacc_s[0] = 32'b0;
  assign facc_s[0] = 32'b0;
  for (genvar g = 0; g < mem_latency_p; g++) begin : g_pipe_hit
    assign iacc_s[g+1] = iacc_s[g] | ({31'b0, pipe_v_q[g] & ~pipe_fp_q[g]} << pipe_addr_q[g]);
    assign facc_s[g+1] = facc_s[g] | ({31'b0, pipe_v_q[g] &  pipe_fp_q[g]} << pipe_addr_q[g]);
  end

  // Hazard detection from registered state only; a writeback does not bypass.
  always_comb begin
    ihaz_s = (ibusy_q | iacc_s[mem_latency_p]) & 32'hFFFF_FFFE;
    fhaz_s = fbusy_q | facc_s[mem_latency_p];
    src_haz_s = (sb_if.isd_irs1_v_i & ihaz_s[sb_if.isd_rs1_addr_i])
              | (sb_if.isd_irs2_v_i & ihaz_s[sb_if.isd_rs2_addr_i])
              | (sb_if.isd_frs1_v_i & fhaz_s[sb_if.isd_rs1_addr_i])
              | (sb_if.isd_frs2_v_i & fhaz_s[sb_if.isd_rs2_addr_i])
              | (sb_if.isd_frs3_v_i & fhaz_s[sb_if.isd_rs3_addr_i]);
    struct_haz_s = sb_if.isd_long_v_i & (credits_q == max_credits_lp);
    fence_haz_s  = sb_if.isd_fence_v_i & ((credits_q != 4'd0) | (|pipe_v_q));
  end

  assign sb_if.dispatch_v_o = ~(src_haz_s | struct_haz_s | fence_haz_s);
  assign sb_if.credits_o    = credits_q;

  // State registers; reset overrides every same-cycle update.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ibusy_q     <= 32'b0;
      fbusy_q     <= 32'b0;
      credits_q   <= 4'd0;
      pipe_v_q    <= {mem_latency_p{1'b0}};
      pipe_fp_q   <= {mem_latency_p{1'b0}};
      pipe_addr_q <= '0;
    end else begin
      ibusy_q     <= ibusy_d;
      fbusy_q     <= fbusy_d;
      credits_q   <= credits_d;
      pipe_v_q    <= pipe_v_d;
      pipe_fp_q   <= pipe_fp_d;
      pipe_addr_q <= pipe_addr_d;
    end
  end

  bp_be_scoreboard_chk u_chk (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .underflow_i (underflow_s),
    .overflow_i  (overflow_s)
  );
endmodule

// File: tb/tb_bp_be_scoreboard.sv
// Scoreboard-style bench for bp_be_scoreboard. The driver pushes the
// expected {dispatch_v_o, credits_o} for every cycle it drives. A monitor on
// the falling edge pops each entry and compares it with the DUT. Directed
// scenarios use hand-derived constants. The random phase uses an abstract
// model: busy sets, an integer credit count and a queue of aged loads.
module tb_bp_be_scoreboard;
  localparam int LC = 4;
  localparam int ML = 2;

  typedef struct packed {
    bit rst, v, poison, irs1, irs2, frs1, frs2, frs3;
    bit [4:0] rs1, rs2, rs3;
    bit ird, frd;
    bit [4:0] rd;
    bit lng, mem, fence;
    bit iwb;
    bit [4:0] iwb_a;
    bit fwb;
    bit [4:0] fwb_a;
    bit flush;
  } stim_t;

  typedef struct packed { bit d; bit [3:0] c; bit [7:0] tag; } exp_t;
  typedef struct packed { bit [4:0] a; bit fp; int age; } pe_t;
  typedef struct packed { bit fp; bit [4:0] a; } ob_t;

  logic clk = 1'b0;
  logic reset_i;
  bp_be_scoreboard_if sif();

  bp_be_scoreboard #(.long_credits_p(LC), .mem_latency_p(ML)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .sb_if   (sif)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int tag = 0;

  // Reference model state
  bit [31:0] m_ib, m_fb;
  int m_cred = 0;
  pe_t m_pipe[$];
  ob_t outst[$];

  function automatic bit m_disp(input stim_t s);
    bit [31:0] ih, fh;
    bit src;
    ih = m_ib;
    fh = m_fb;
    foreach (m_pipe[k]) begin
      if (m_pipe[k].fp) fh[m_pipe[k].a] = 1'b1;
      else ih[m_pipe[k].a] = 1'b1;
    end
    ih[0] = 1'b0;
    src = (s.irs1 && ih[s.rs1]) || (s.irs2 && ih[s.rs2]) ||
          (s.frs1 && fh[s.rs1]) || (s.frs2 && fh[s.rs2]) || (s.frs3 && fh[s.rs3]);
    return !(src || (s.lng && m_cred == LC) ||
             (s.fence && (m_cred != 0 || m_pipe.size() != 0)));
  endfunction

  task automatic m_step(input stim_t s);
    bit rec;
    int nc;
    if (s.rst) begin
      m_ib = '0; m_fb = '0; m_cred = 0; m_pipe.delete();
    end else begin
      rec = s.v && !s.poison;
      nc = m_cred + ((rec && s.lng) ? 1 : 0) - (s.iwb ? 1 : 0) - (s.fwb ? 1 : 0);
      if (nc < 0) nc = 0;
      if (nc > LC) nc = LC;
      m_cred = nc;
      if (s.iwb) m_ib[s.iwb_a] = 1'b0;
      if (s.fwb) m_fb[s.fwb_a] = 1'b0;
      if (rec && s.lng) begin
        if (s.ird && s.rd != 5'd0) m_ib[s.rd] = 1'b1;
        if (s.frd) m_fb[s.rd] = 1'b1;
      end
      foreach (m_pipe[k]) m_pipe[k].age++;
      for (int k = m_pipe.size() - 1; k >= 0; k--)
        if (m_pipe[k].age >= ML) m_pipe.delete(k);
      if (rec && s.mem && (s.ird || s.frd)) m_pipe.push_back('{a: s.rd, fp: s.frd, age: 0});
      if (s.flush) m_pipe.delete();
    end
  endtask

  task automatic drive(input stim_t s);
    reset_i = s.rst;
    sif.isd_v_i = s.v;             sif.poison_i = s.poison;
    sif.isd_irs1_v_i = s.irs1;     sif.isd_irs2_v_i = s.irs2;
    sif.isd_frs1_v_i = s.frs1;     sif.isd_frs2_v_i = s.frs2;
    sif.isd_frs3_v_i = s.frs3;
    sif.isd_rs1_addr_i = s.rs1;    sif.isd_rs2_addr_i = s.rs2;
    sif.isd_rs3_addr_i = s.rs3;
    sif.isd_ird_w_v_i = s.ird;     sif.isd_frd_w_v_i = s.frd;
    sif.isd_rd_addr_i = s.rd;
    sif.isd_long_v_i = s.lng;      sif.isd_mem_v_i = s.mem;
    sif.isd_fence_v_i = s.fence;
    sif.iwb_v_i = s.iwb;           sif.iwb_addr_i = s.iwb_a;
    sif.fwb_v_i = s.fwb;           sif.fwb_addr_i = s.fwb_a;
    sif.flush_i = s.flush;
  endtask

  // One clock: drive, queue expectation (wd/wc < 0 -> from the model), advance the model.
  task automatic cyc(input stim_t s, input int wd, input int wc);
    exp_t e;
    #1;
    drive(s);
    e.d = (wd < 0) ? m_disp(s) : wd[0];
    e.c = (wc < 0) ? m_cred[3:0] : wc[3:0];
    e.tag = tag[7:0];
    exp_q.push_back(e);
    @(posedge clk);
    m_step(s);
  endtask

  // Monitor: compare every queued expectation with the DUT on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (sif.dispatch_v_o !== e.d) begin
        n_bad++;
        $display("FAIL dispatch tag=%0d t=%0t got=%b want=%b", e.tag, $time, sif.dispatch_v_o, e.d);
      end
      n_cmp++;
      if (sif.credits_o !== e.c) begin
        n_bad++;
        $display("FAIL credits tag=%0d t=%0t got=%0d want=%0d", e.tag, $time, sif.credits_o, e.c);
      end
    end
  end

  task automatic rand_cycle();
    stim_t s;
    ob_t o;
    int r;
    s = '0;
    s.rs1 = 5'($urandom_range(0, 7));
    s.rs2 = 5'($urandom_range(0, 7));
    s.rs3 = 5'($urandom_range(0, 7));
    {s.irs1, s.irs2, s.frs1, s.frs2, s.frs3} = 5'($urandom);
    r = $urandom_range(0, 7);
    s.lng = (r < 3);
    s.mem = (r == 3 || r == 4);
    s.fence = (r == 5);
    if ($urandom_range(0, 1) == 0) s.ird = 1'b1;
    else s.frd = 1'b1;
    s.rd = 5'($urandom_range(0, 7));
    s.poison = ($urandom_range(0, 7) == 0);
    s.v = m_disp(s) && ($urandom_range(0, 3) != 0);
    for (int n = 0; n < 2; n++) begin
      if (outst.size() != 0 && $urandom_range(0, 2) == 0) begin
        int idx;
        idx = $urandom_range(0, outst.size() - 1);
        o = outst[idx];
        if (o.fp && !s.fwb) begin
          s.fwb = 1'b1; s.fwb_a = o.a; outst.delete(idx);
        end else if (!o.fp && !s.iwb) begin
          s.iwb = 1'b1; s.iwb_a = o.a; outst.delete(idx);
        end
      end
    end
    s.flush = ($urandom_range(0, 15) == 0);
    s.rst = ($urandom_range(0, 249) == 0);
    if (s.v && !s.poison && s.lng) outst.push_back('{fp: s.frd, a: s.rd});
    if (s.rst) outst.delete();
    cyc(s, -1, -1);
  endtask

  initial begin
    stim_t s;
    s = '0; s.rst = 1'b1;
    drive(s);
    repeat (2) @(posedge clk);

    // Reset state: any candidate dispatches; a record during reset is dropped.
    tag = 1;
    s = '0; s.rst = 1; s.v = 1; s.lng = 1; s.ird = 1; s.rd = 5; s.fence = 1;
    s.irs1 = 1; s.rs1 = 3;                                  cyc(s, 1, 0);
    s = '0; s.irs1 = 1; s.rs1 = 5; s.fence = 1; s.lng = 1;  cyc(s, 1, 0);

    // Long div to x5, dependent read stalls until the cycle after iwb.
    tag = 2;
    s = '0; s.v = 1; s.lng = 1; s.ird = 1; s.rd = 5;        cyc(s, 1, 0);
    s = '0; s.irs1 = 1; s.rs1 = 5;                          cyc(s, 0, 1);
                                                            cyc(s, 0, 1);
    s.iwb = 1; s.iwb_a = 5;                                 cyc(s, 0, 1);
    s.iwb = 0;                                              cyc(s, 1, 0);

    // Credit exhaustion with four FP long ops, released by one fwb.
    tag = 3;
    for (int i = 1; i <= 4; i++) begin
      s = '0; s.v = 1; s.lng = 1; s.frd = 1; s.rd = 5'(i);  cyc(s, 1, i - 1);
    end
    s = '0; s.lng = 1; s.frd = 1; s.rd = 9;                 cyc(s, 0, 4);
    s.fwb = 1; s.fwb_a = 1;                                 cyc(s, 0, 4);
    s.fwb = 0;                                              cyc(s, 1, 3);
    for (int i = 2; i <= 4; i++) begin
      s = '0; s.fwb = 1; s.fwb_a = 5'(i);                   cyc(s, 1, 5 - i);
    end
    s = '0;                                                 cyc(s, 1, 0);

    // Load-use stall of exactly two cycles, then the same with a flush.
    tag = 4;
    s = '0; s.v = 1; s.mem = 1; s.ird = 1; s.rd = 7;        cyc(s, 1, 0);
    s = '0; s.irs2 = 1; s.rs2 = 7;                          cyc(s, 0, 0);
                                                            cyc(s, 0, 0);
                                                            cyc(s, 1, 0);
    s = '0; s.v = 1; s.mem = 1; s.ird = 1; s.rd = 7;        cyc(s, 1, 0);
    s = '0; s.irs2 = 1; s.rs2 = 7; s.flush = 1;             cyc(s, 0, 0);
    s.flush = 0;                                            cyc(s, 1, 0);

    // Same-cycle iwb and new long record to x9: set wins, credits net zero.
    tag = 5;
    s = '0; s.v = 1; s.lng = 1; s.ird = 1; s.rd = 9;        cyc(s, 1, 0);
    s.iwb = 1; s.iwb_a = 9;                                 cyc(s, 1, 1);
    s = '0; s.irs1 = 1; s.rs1 = 9;                          cyc(s, 0, 1);
    s.iwb = 1; s.iwb_a = 9;                                 cyc(s, 0, 1);
    s.iwb = 0;                                              cyc(s, 1, 0);

    // Fence waits on credits and on in-flight loads; poison and x0 never stall.
    tag = 6;
    s = '0; s.v = 1; s.lng = 1; s.frd = 1; s.rd = 3;        cyc(s, 1, 0);
    s = '0; s.fence = 1;                                    cyc(s, 0, 1);
    s.fwb = 1; s.fwb_a = 3;                                 cyc(s, 0, 1);
    s.fwb = 0;                                              cyc(s, 1, 0);
    s = '0; s.v = 1; s.mem = 1; s.frd = 1; s.rd = 3;        cyc(s, 1, 0);
    s = '0; s.fence = 1;                                    cyc(s, 0, 0);
                                                            cyc(s, 0, 0);
                                                            cyc(s, 1, 0);
    s = '0; s.v = 1; s.poison = 1; s.lng = 1; s.ird = 1; s.rd = 12; cyc(s, 1, 0);
    s = '0; s.irs1 = 1; s.rs1 = 12; s.fence = 1;            cyc(s, 1, 0);
    s = '0; s.v = 1; s.lng = 1; s.ird = 1; s.rd = 0;        cyc(s, 1, 0);
    s = '0; s.irs1 = 1; s.irs2 = 1;                         cyc(s, 1, 1);
    s.iwb = 1; s.iwb_a = 0;                                 cyc(s, 1, 1);
    s.iwb = 0;                                              cyc(s, 1, 0);

    // Reset mid-operation discards the busy bit and the credit.
    tag = 7;
    s = '0; s.v = 1; s.lng = 1; s.ird = 1; s.rd = 5;        cyc(s, 1, 0);
    s = '0; s.rst = 1; s.iwb = 1; s.iwb_a = 5;              cyc(s, 1, 1);
    s = '0; s.irs1 = 1; s.rs1 = 5;                          cyc(s, 1, 0);

    // Randomized traffic against the model.
    tag = 8;
    outst.delete();
    s = '0; s.rst = 1;                                      cyc(s, -1, -1);
    for (int i = 0; i < 3000; i++) rand_cycle();
    s = '0;                                                 cyc(s, -1, -1);

    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bp_be_scoreboard.md
BP_BE_SCOREBOARD -- requirements
Module: bp_be_scoreboard

Interface
REQ-001 Parameter: long_credits_p, default 4, max outstanding long-latency ops (iterative div/FP); legal range 1..15.
REQ-002 Parameter: mem_latency_p, default 2, cycles before a load result is forwardable; legal range 1..4.
REQ-003 clk_i  input  1  clock; the block SHALL use this one clock only, all state on its rising edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 isd_v_i  input  1  an instruction issues this cycle (already qualified by dispatch_v_o).
REQ-006 poison_i  input  1  the issuing instruction is squashed; no state is recorded for it.
REQ-007 isd_irs1_v_i / isd_irs2_v_i  input  1 each  integer source reads.
REQ-008 isd_frs1_v_i / isd_frs2_v_i / isd_frs3_v_i  input  1 each  FP source reads.
REQ-009 isd_rs1_addr_i / isd_rs2_addr_i / isd_rs3_addr_i  input  5 each  source register addresses.
REQ-010 isd_ird_w_v_i / isd_frd_w_v_i  input  1 each  instruction writes an int / FP destination.
REQ-011 isd_rd_addr_i  input  5  destination address.
REQ-012 isd_long_v_i / isd_mem_v_i / isd_fence_v_i  input  1 each  instruction class.
REQ-013 iwb_v_i, iwb_addr_i / fwb_v_i, fwb_addr_i  input  1, 5 each  long-op writeback to int / FP file.
REQ-014 flush_i  input  1  pipeline rollback; squashes in-flight mem ops.
REQ-015 dispatch_v_o  output  1  no hazard; the candidate in ISD may issue.
REQ-016 credits_o  output  4  outstanding long-op count.

Function
REQ-017 State: 32-bit int busy vector, 32-bit FP busy vector, credit counter, mem_latency_p-deep valid/addr/fp-flag shift pipe.
REQ-018 Record event = isd_v_i & ~poison_i; no state update without it.
REQ-019 Long record with isd_ird_w_v_i sets int busy[rd]; with isd_frd_w_v_i sets FP busy[rd]; int rd=0 is never set.
REQ-020 iwb_v_i clears int busy[iwb_addr_i]; fwb_v_i clears FP busy[fwb_addr_i]; writeback to a non-busy register is ignored.
REQ-021 Same-cycle set and clear of the same register: set wins (busy remains 1).
REQ-022 Credits: +1 per long record, -1 per iwb_v_i, -1 per fwb_v_i; net change in {-2..+1} applied in one cycle.
REQ-023 Credits saturate at 0 on underflow and at long_credits_p on overflow; either condition fires a simulation assertion.
REQ-024 Mem record with a destination write enters pipe stage 0 (addr, fp flag); the pipe shifts one stage per cycle and drops at stage mem_latency_p-1.
REQ-025 flush_i clears all pipe valid bits in that cycle, including any same-cycle entry; busy vectors and credits are unaffected (committed long ops always write back).
REQ-026 Source hazard: a valid source matches a busy bit of its file, or matches a valid pipe entry of the same file (int x0 never matches).
REQ-027 Structural hazard: isd_long_v_i & credits == long_credits_p.
REQ-028 Fence hazard: isd_fence_v_i & (credits != 0 | any pipe entry valid).
REQ-029 dispatch_v_o = ~(source | structural | fence hazard); combinational from current state and ISD inputs, with no same-cycle writeback bypass (a wb clears hazard the next cycle).
REQ-030 Latency: a record affects dispatch_v_o from the next cycle; the clear takes effect the cycle after writeback.

Reset
REQ-031 On reset_i: busy vectors 0, credits 0, pipe empty; credits_o=0; dispatch_v_o=1 for any ISD input the next cycle.
REQ-032 reset_i overrides all same-cycle records, writebacks and flushes.
REQ-033 Reset mid-operation discards all outstanding state; late writebacks after reset are ignored without underflow beyond 0.

Verification
REQ-034 Long div to x5 issues, next cycle rs1=x5 -> dispatch_v_o=0 until cycle after iwb_v_i, addr=5; credits_o 1 -> 0.
REQ-035 Four long ops issue back-to-back (credits_o=4), fifth long candidate -> dispatch_v_o=0; one fwb -> dispatch_v_o=1 next cycle.
REQ-036 Load to x7 (mem_latency_p=2), dependent rs2=x7 -> stalls exactly 2 cycles; with flush_i in cycle 1 -> dispatch_v_o=1 in cycle 2.
REQ-037 Same cycle: iwb to x9 and new long record to x9 -> busy[9] stays 1, credits_o unchanged.
REQ-038 Fence with credits_o=1 -> dispatch_v_o=0; after fwb -> 1; poisoned long issue -> credits_o unchanged, no busy set; rd=x0 never stalls.
